// File: rtl/mpp_mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM encoding,
// wait-state limits and requester identifiers.
package mpp_mem_arbiter_pkg;

    // Access sequencing states.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StDone   = 2'd3
    } state_e;

    // The wait-state down-counter is three bits wide, which caps WAIT_STATES.
    localparam int unsigned CntWidth      = 3;
    localparam int unsigned WaitStatesMax = 7;

    localparam int unsigned AddrWidth = 16;
    localparam int unsigned DataWidth = 8;

    // Requester identifiers as stored in the owner / last-served registers.
    localparam logic ReqM0 = 1'b0;
    localparam logic ReqM1 = 1'b1;

    // Round-robin pick between two requesters: on contention the one that was
    // not served last wins; a lone requester always wins.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        logic winner;
        winner = ReqM0;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = ReqM1;
        end
        return winner;
    endfunction

endpackage

// File: rtl/mpp_mem_arbiter.sv
// Two-requester round-robin arbiter in front of an asynchronous SRAM-style
// memory. Each access runs SETUP -> ACCESS (WAIT_STATES+1 cycles) -> DONE and
// completes from operands latched at grant time.
module mpp_mem_arbiter
    import mpp_mem_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [AddrWidth-1:0] m0_addr,
    input  logic [DataWidth-1:0] m0_wdata,
    output logic                 m0_gnt,
    output logic                 m0_done,
    output logic [DataWidth-1:0] m0_rdata,

    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [AddrWidth-1:0] m1_addr,
    input  logic [DataWidth-1:0] m1_wdata,
    output logic                 m1_gnt,
    output logic                 m1_done,
    output logic [DataWidth-1:0] m1_rdata,

    output logic                 mem_cs_n,
    output logic                 mem_we_n,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    input  logic [DataWidth-1:0] mem_rdata
);

    // Out-of-range parameter values saturate rather than wrap the counter.
    localparam int unsigned WaitEff =
        (WAIT_STATES > WaitStatesMax) ? WaitStatesMax : WAIT_STATES;
    localparam logic [CntWidth-1:0] WaitLoad = CntWidth'(WaitEff);

    state_e               state_q, state_d;
    logic                 owner_q, owner_d;   // requester owning the current access
    logic                 last_q,  last_d;    // requester served most recently
    logic                 we_q,    we_d;
    logic [AddrWidth-1:0] addr_q,  addr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [CntWidth-1:0]  cnt_q,   cnt_d;
    logic [DataWidth-1:0] rdata0_q, rdata0_d;
    logic [DataWidth-1:0] rdata1_q, rdata1_d;
    logic                 winner;
    logic                 busy;

    // Round-robin winner among the current requests.
    always_comb begin
        winner = rr_pick(m0_req, m1_req, last_q);
    end

    // Next-state logic: grant and latch in IDLE, count wait states in ACCESS,
    // capture read data on the final ACCESS cycle.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        unique case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    state_d = StSetup;
                    owner_d = winner;
                    last_d  = winner;
                    if (winner == ReqM1) begin
                        we_d    = m1_we;
                        addr_d  = m1_addr;
                        wdata_d = m1_wdata;
                    end else begin
                        we_d    = m0_we;
                        addr_d  = m0_addr;
                        wdata_d = m0_wdata;
                    end
                end
            end
            StSetup: begin
                state_d = StAccess;
                cnt_d   = WaitLoad;
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                    if (!we_q) begin
                        if (owner_q == ReqM1) begin
                            rdata1_d = mem_rdata;
                        end else begin
                            rdata0_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset also aborts
    // any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            owner_q  <= ReqM0;
            last_q   <= ReqM1;   // so requester 0 wins the first contention
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Outputs decoded from registered state only.
    assign busy      = (state_q != StIdle);
    assign m0_gnt    = busy && (owner_q == ReqM0);
    assign m1_gnt    = busy && (owner_q == ReqM1);
    assign m0_done   = (state_q == StDone) && (owner_q == ReqM0);
    assign m1_done   = (state_q == StDone) && (owner_q == ReqM1);
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign mem_cs_n  = (state_q != StAccess);
    assign mem_we_n  = !((state_q == StAccess) && we_q);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mpp_mem_arbiter.sv
// Directed bench for mpp_mem_arbiter: one instance with WAIT_STATES=2 and one
// with WAIT_STATES=0, checked with immediate assertions against hand values.
module tb_mpp_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m1_addr, mem_addr;
    logic [7:0]  m0_wdata, m1_wdata, mem_wdata, mem_rdata;
    logic        m0_gnt, m1_gnt, m0_done, m1_done, mem_cs_n, mem_we_n;
    logic [7:0]  m0_rdata, m1_rdata;

    logic        z_m0_req, z_m0_we, z_m1_req, z_m1_we;
    logic [15:0] z_m0_addr, z_m1_addr, z_mem_addr;
    logic [7:0]  z_m0_wdata, z_m1_wdata, z_mem_wdata, z_mem_rdata;
    logic        z_m0_gnt, z_m1_gnt, z_m0_done, z_m1_done, z_mem_cs_n, z_mem_we_n;
    logic [7:0]  z_m0_rdata, z_m1_rdata;

    int errors = 0;
    int checks = 0;

    int done_cyc, done_cnt, cs_cnt, wel_cnt, we_bad, stab_bad, oth_gnt, oth_done, oh_bad;
    int order[4];

    always #5 clk = ~clk;

    mpp_mem_arbiter #(.WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
        .mem_cs_n(mem_cs_n), .mem_we_n(mem_we_n), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mpp_mem_arbiter #(.WAIT_STATES(0)) dut_w0 (
        .clk(clk), .rst(rst),
        .m0_req(z_m0_req), .m0_we(z_m0_we), .m0_addr(z_m0_addr), .m0_wdata(z_m0_wdata),
        .m0_gnt(z_m0_gnt), .m0_done(z_m0_done), .m0_rdata(z_m0_rdata),
        .m1_req(z_m1_req), .m1_we(z_m1_we), .m1_addr(z_m1_addr), .m1_wdata(z_m1_wdata),
        .m1_gnt(z_m1_gnt), .m1_done(z_m1_done), .m1_rdata(z_m1_rdata),
        .mem_cs_n(z_mem_cs_n), .mem_we_n(z_mem_we_n), .mem_addr(z_mem_addr),
        .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one access on the WAIT_STATES=2 instance for 14 cycles, starting in
    // IDLE at #1 after an edge. Cycle k is the one after the k-th edge.
    task automatic run_one(input bit who, input logic we, input logic [15:0] addr,
                           input logic [7:0] wd, input int drop_at);
        done_cyc = -1; done_cnt = 0; cs_cnt = 0; wel_cnt = 0; we_bad = 0;
        stab_bad = 0; oth_gnt = 0; oth_done = 0; oh_bad = 0;
        if (who) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd;
        end
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(posedge clk); #1;
            if (!mem_cs_n) cs_cnt++;
            if (!mem_we_n) wel_cnt++;
            if (!mem_we_n && mem_cs_n) we_bad++;
            if (!mem_cs_n && (mem_addr !== addr || mem_wdata !== wd)) stab_bad++;
            if (m0_gnt && m1_gnt) oh_bad++;
            if (who ? m0_gnt : m1_gnt) oth_gnt++;
            if (who ? m0_done : m1_done) oth_done++;
            if (cyc == drop_at) begin
                if (who) m1_req = 1'b0; else m0_req = 1'b0;
            end
            if (who ? m1_done : m0_done) begin
                if (done_cyc < 0) done_cyc = cyc;
                done_cnt++;
                if (who) m1_req = 1'b0; else m0_req = 1'b0;
            end
        end
    endtask

    initial begin
        int ng, nd;
        logic p0, p1;

        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        mem_rdata = 8'h00;
        z_m0_req = 0; z_m0_we = 0; z_m0_addr = '0; z_m0_wdata = '0;
        z_m1_req = 0; z_m1_we = 0; z_m1_addr = '0; z_m1_wdata = '0;
        z_mem_rdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;

        // Reset values.
        chk("rst_cs_n", 32'(mem_cs_n), 32'd1);
        chk("rst_we_n", 32'(mem_we_n), 32'd1);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_gnt", 32'({m0_gnt, m1_gnt}), 32'h0);
        chk("rst_done", 32'({m0_done, m1_done}), 32'h0);
        chk("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'h0);

        rst = 1'b0;
        @(posedge clk); #1;

        // WAIT_STATES=0: m0 reads 0x0010.
        z_m0_req = 1'b1; z_m0_addr = 16'h0010; z_mem_rdata = 8'h3C;
        done_cyc = -1; cs_cnt = 0; done_cnt = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk); #1;
            if (!z_mem_cs_n) cs_cnt++;
            if (z_m0_done) begin
                if (done_cyc < 0) done_cyc = cyc;
                done_cnt++;
                z_m0_req = 1'b0;
            end
        end
        chk("w0_done_cyc", 32'(done_cyc), 32'd3);
        chk("w0_cs_cycles", 32'(cs_cnt), 32'd1);
        chk("w0_done_pulses", 32'(done_cnt), 32'd1);
        chk("w0_rdata", 32'(z_m0_rdata), 32'h3C);

        // Single read, m0, 0x0002.
        mem_rdata = 8'h44;
        run_one(1'b0, 1'b0, 16'h0002, 8'h00, 0);
        chk("rd_done_cyc", 32'(done_cyc), 32'd5);
        chk("rd_cs_cycles", 32'(cs_cnt), 32'd3);
        chk("rd_we_low", 32'(wel_cnt), 32'd0);
        chk("rd_done_pulses", 32'(done_cnt), 32'd1);
        chk("rd_m0_rdata", 32'(m0_rdata), 32'h44);
        chk("rd_m1_idle", 32'(oth_gnt + oth_done), 32'd0);

        // Write, m1, 0x1234 <- 0xC1.
        mem_rdata = 8'hEE;
        run_one(1'b1, 1'b1, 16'h1234, 8'hC1, 0);
        chk("wr_done_cyc", 32'(done_cyc), 32'd5);
        chk("wr_cs_cycles", 32'(cs_cnt), 32'd3);
        chk("wr_we_low", 32'(wel_cnt), 32'd3);
        chk("wr_we_outside_cs", 32'(we_bad), 32'd0);
        chk("wr_addr_data_stable", 32'(stab_bad), 32'd0);
        chk("wr_mem_addr", 32'(mem_addr), 32'h1234);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'hC1);
        chk("wr_m0_idle", 32'(oth_gnt + oth_done), 32'd0);
        chk("wr_m1_rdata_kept", 32'(m1_rdata), 32'h00);
        chk("wr_m0_rdata_kept", 32'(m0_rdata), 32'h44);

        // Read, m1: m0_rdata must not move.
        mem_rdata = 8'h5A;
        run_one(1'b1, 1'b0, 16'h00A0, 8'h00, 0);
        chk("rd1_m1_rdata", 32'(m1_rdata), 32'h5A);
        chk("rd1_m0_rdata_kept", 32'(m0_rdata), 32'h44);

        // m0 drops req in the middle of ACCESS.
        mem_rdata = 8'h6B;
        run_one(1'b0, 1'b0, 16'h0030, 8'h00, 3);
        chk("drop_done_cyc", 32'(done_cyc), 32'd5);
        chk("drop_done_pulses", 32'(done_cnt), 32'd1);
        chk("drop_m0_rdata", 32'(m0_rdata), 32'h6B);
        chk("drop_idle_gnt", 32'({m0_gnt, m1_gnt}), 32'h0);
        chk("drop_idle_cs_n", 32'(mem_cs_n), 32'd1);

        // Reset, then four contended accesses: expect m0, m1, m0, m1.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rdata = 8'h77;
        m0_we = 0; m0_addr = 16'h0100; m1_we = 0; m1_addr = 16'h0200;
        m0_req = 1'b1; m1_req = 1'b1;
        ng = 0; nd = 0; p0 = 1'b0; p1 = 1'b0; oh_bad = 0;
        for (int i = 0; i < 4; i++) order[i] = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (m0_gnt && m1_gnt) oh_bad++;
            if (m0_gnt && !p0 && ng < 4) begin order[ng] = 0; ng++; end
            if (m1_gnt && !p1 && ng < 4) begin order[ng] = 1; ng++; end
            p0 = m0_gnt; p1 = m1_gnt;
            if (m0_done || m1_done) nd++;
            if (nd >= 4) begin m0_req = 1'b0; m1_req = 1'b0; end
        end
        chk("rr_grant0", 32'(order[0]), 32'd0);
        chk("rr_grant1", 32'(order[1]), 32'd1);
        chk("rr_grant2", 32'(order[2]), 32'd0);
        chk("rr_grant3", 32'(order[3]), 32'd1);
        chk("rr_dones", 32'(nd), 32'd4);
        chk("rr_onehot", 32'(oh_bad), 32'd0);
        chk("rr_rdata", 32'({m0_rdata, m1_rdata}), 32'h7777);

        // Reset during ACCESS aborts the access.
        mem_rdata = 8'h99;
        m0_we = 0; m0_addr = 16'h0003; m0_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_in_access", 32'(mem_cs_n), 32'd0);
        rst = 1'b1; m0_req = 1'b0;
        @(posedge clk); #1;
        chk("abort_cs_n", 32'(mem_cs_n), 32'd1);
        chk("abort_gnt", 32'({m0_gnt, m1_gnt}), 32'h0);
        chk("abort_done", 32'({m0_done, m1_done}), 32'h0);
        chk("abort_rdata_cleared", 32'(m0_rdata), 32'h00);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_no_late_done", 32'({m0_done, m1_done, mem_cs_n}), 32'h1);

        // Next m0 request after the abort is served normally.
        mem_rdata = 8'h5C;
        run_one(1'b0, 1'b0, 16'h0004, 8'h00, 0);
        chk("post_abort_done_cyc", 32'(done_cyc), 32'd5);
        chk("post_abort_rdata", 32'(m0_rdata), 32'h5C);
        chk("post_abort_cs_cycles", 32'(cs_cnt), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
